halfband_interp_sym: RTL and testbench
======================================

Name: halfband_interp_sym

Overview:
- Transmit-side counterpart of the symmetric halfband decimating stage: a polyphase halfband interpolator (x2), 15-tap symmetric kernel, 1s17 data.
- Input samples arrive at rate fs, qualified by sam_clk_en. Output samples leave at 2fs, qualified by sys_clk2_en.
- Even output phase: 8-tap symmetric FIR built from 4 pre-adds, 4 multipliers and a pipelined adder tree.
- Odd output phase: the center tap (1.0), i.e. a pure delay of the input.

Parameters:
- WIDTH, 18, data width of x_in and y (1s17).
- CWIDTH, 18, coefficient width (1s17).
- ACCW, 40, accumulator width; must be at least WIDTH+CWIDTH+3.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sam_clk_en  in  1  input-rate strobe, 1 cycle wide; must coincide with a sys_clk2_en.
- sys_clk2_en  in  1  output-rate strobe (2x sam_clk_en), 1 cycle wide.
- x_in  in  WIDTH  signed 1s17 input sample.
- y  out  WIDTH  signed 1s17 interpolated output, registered.
- y_phase  out  1  0 = y holds an even (filtered) sample, 1 = y holds an odd (delayed) sample.

Behaviour:
- Reset: reset is synchronous, active-high, on clock sys_clk. It clears the delay line x[0..7], every pipeline register, even_r, odd_r, odd_hold, y=0 and y_phase=0. Reset asserted mid-operation abandons in-flight samples; the first valid output follows the second sam_clk_en after reset is released.
- Delay line: on sam_clk_en, x[0]<=x_in and x[k]<=x[k-1] for k=1..7. x[0] is the newest sample. The line holds otherwise.
- Coefficients (1s17, constant): c0=-320, c1=3144, c2=-15696, c3=78408. Even-phase DC gain = 2*sum = 131072 = 1.0. Odd-phase coefficient = 1.0.
- Pipeline (sample m shifted in at edge t):
  - t+1: p_k <= x[k]+x[7-k], k=0..3, 19-bit exact; d1 <= x[3].
  - t+2: m_k <= c_k*p_k, 37-bit exact; d2 <= d1.
  - t+3: even_r <= rnd_sat(sum of m_k in ACCW bits); odd_r <= d2.
- rnd_sat: add 2^16, arithmetic shift right 17, then saturate to [-131072, 131071]; without the optional feature, wrap instead (see below).
- Output register, sys_clk2_en with sam_clk_en: y<=even_r, odd_hold<=odd_r, y_phase<=0.
- Output register, sys_clk2_en without sam_clk_en: y<=odd_hold, y_phase<=1. A repeated odd strobe re-outputs odd_hold.
- sam_clk_en without sys_clk2_en (protocol violation): the delay line still shifts; y, y_phase and odd_hold hold.
- Timing constraint: the sam_clk_en period is at least 8 sys_clk cycles.
- Latency: the output pair for sample m is y[2m] at the sam_clk_en of sample m+1, then y[2m+1] at the next sys_clk2_en.
- Sequence relations: y[2m] = sum_k c_k*(x[m-k]+x[m-7+k]), k=0..3; y[2m+1] = x[m-3].

Optional Feature:
- Macro HB_INTERP_SAT_EN.
- Defined: rnd_sat clamps to +131071 / -131072 on overflow.
- Undefined: the low 18 bits of the rounded sum are taken (two's-complement wrap). This saves logic when the input is guaranteed to be at most 0.67 FS.
- The odd phase is exact in both builds.

Test Plan:
- Reset/idle: hold reset 5 cycles, then x_in=0 -> y=0 and y_phase=0 throughout. Assert reset mid-stream -> y=0 on the next edge.
- Impulse: x_in=65536 for one sample (m=0), zeros after. Expected output pairs from sample 1 onward:
  - even: -160, 1572, -7848, 39204, 39204, -7848, 1572, -160.
  - odd: 0, 0, 0, 65536, 0, 0, 0, 0.
  - y_phase alternates 0,1.
- DC: constant x_in=65536 -> after 9 input samples, y=65536 on every strobe. Constant x_in=131071 -> y=131071 every strobe.
- Overflow: input sequence -131071, 131071, -131071, 131071, 131071, -131071, 131071, -131071 -> next even output is 131071 with HB_INTERP_SAT_EN, or -67009 without it (raw rounded value 195135).
- Strobe edge cases: two sys_clk2_en without sam_clk_en -> second odd output repeats odd_hold with y_phase=1. sam_clk_en without sys_clk2_en -> y unchanged, delay line shifted (verified by the subsequent impulse timing).

Source files
------------

// File: rtl/halfband_interp_sym.sv
// x2 polyphase halfband interpolator: 15-tap symmetric kernel with the even phase as an 8-tap FIR and the odd phase as a pure delay.
// Define HB_INTERP_SAT_EN to saturate the even-phase result instead of letting it wrap.
module halfband_interp_sym #(
    parameter int WIDTH  = 18,
    parameter int CWIDTH = 18,
    parameter int ACCW   = 40
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    sys_clk2_en,
    input  logic signed [WIDTH-1:0] x_in,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_phase
);

    localparam int PW    = WIDTH + 1;
    localparam int MW    = PW + CWIDTH;
    localparam int SHIFT = CWIDTH - 1;
    localparam int RW    = ACCW - SHIFT;

    localparam logic signed [CWIDTH-1:0] COEF [4] = '{
        CWIDTH'(-320), CWIDTH'(3144), CWIDTH'(-15696), CWIDTH'(78408)
    };

    localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1) <<< (SHIFT - 1);

    logic signed [WIDTH-1:0] x_q [8];
    logic signed [WIDTH-1:0] x_d [8];

    logic signed [PW-1:0]    p_q [4];
    logic signed [PW-1:0]    p_d [4];
    logic signed [WIDTH-1:0] d1_q, d1_d;

    logic signed [MW-1:0]    m_q [4];
    logic signed [MW-1:0]    m_d [4];
    logic signed [WIDTH-1:0] d2_q, d2_d;

    logic signed [WIDTH-1:0] even_r_q, even_r_d;
    logic signed [WIDTH-1:0] odd_r_q, odd_r_d;

    logic signed [WIDTH-1:0] odd_hold_q, odd_hold_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic                    y_phase_q, y_phase_d;

    logic signed [ACCW-1:0]  acc_sum;
    logic signed [ACCW-1:0]  acc_rnd;

    // Delay line only moves on the input-rate strobe, regardless of the output strobe.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            x_d[k] = x_q[k];
        end
        if (sam_clk_en) begin
            x_d[0] = x_in;
            for (int k = 1; k < 8; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    // Arithmetic pipeline runs every cycle; the sample period leaves ample settle time.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            p_d[k] = PW'(x_q[k]) + PW'(x_q[7-k]);
            m_d[k] = MW'(p_q[k]) * MW'(COEF[k]);
        end
        d1_d    = x_q[3];
        d2_d    = d1_q;
        odd_r_d = d2_q;
    end

    always_comb begin
        acc_sum = ACCW'(m_q[0]) + ACCW'(m_q[1]) + ACCW'(m_q[2]) + ACCW'(m_q[3]);
        acc_rnd = acc_sum + RND_HALF;
    end

`ifdef HB_INTERP_SAT_EN
    logic signed [RW-1:0] shifted;
    logic                 ovf;

    always_comb begin
        shifted = RW'(acc_rnd >>> SHIFT);
        ovf     = (shifted[RW-1:WIDTH-1] != {(RW-WIDTH+1){shifted[RW-1]}});
        if (ovf) begin
            even_r_d = shifted[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            even_r_d = shifted[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        even_r_d = WIDTH'(acc_rnd >>> SHIFT);
    end
`endif

    // The even strobe also latches the matching odd sample so the pair leaves together.
    always_comb begin
        y_d        = y_q;
        y_phase_d  = y_phase_q;
        odd_hold_d = odd_hold_q;
        if (sys_clk2_en) begin
            if (sam_clk_en) begin
                y_d        = even_r_q;
                odd_hold_d = odd_r_q;
                y_phase_d  = 1'b0;
            end else begin
                y_d        = odd_hold_q;
                y_phase_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                x_q[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                p_q[k] <= '0;
                m_q[k] <= '0;
            end
            d1_q       <= '0;
            d2_q       <= '0;
            even_r_q   <= '0;
            odd_r_q    <= '0;
            odd_hold_q <= '0;
            y_q        <= '0;
            y_phase_q  <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                x_q[k] <= x_d[k];
            end
            for (int k = 0; k < 4; k++) begin
                p_q[k] <= p_d[k];
                m_q[k] <= m_d[k];
            end
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            even_r_q   <= even_r_d;
            odd_r_q    <= odd_r_d;
            odd_hold_q <= odd_hold_d;
            y_q        <= y_d;
            y_phase_q  <= y_phase_d;
        end
    end

    assign y       = y_q;
    assign y_phase = y_phase_q;

endmodule

// File: tb/tb_halfband_interp_sym.sv
// Scoreboard bench for halfband_interp_sym: driver queues hand-computed outputs, monitor compares on every output strobe.
module tb_halfband_interp_sym;

    logic                sys_clk     = 1'b0;
    logic                reset       = 1'b1;
    logic                sam_clk_en  = 1'b0;
    logic                sys_clk2_en = 1'b0;
    logic signed [17:0]  x_in        = '0;
    logic signed [17:0]  y;
    logic                y_phase;

`ifdef HB_INTERP_SAT_EN
    localparam int EXP_OVF = 131071;
`else
    localparam int EXP_OVF = -67009;
`endif

    halfband_interp_sym #(.WIDTH(18), .CWIDTH(18), .ACCW(40)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sam_clk_en  (sam_clk_en),
        .sys_clk2_en (sys_clk2_en),
        .x_in        (x_in),
        .y           (y),
        .y_phase     (y_phase)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit    chk;
        int    yv;
        bit    ph;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    // Monitor: every output strobe consumes one scoreboard entry.
    always @(posedge sys_clk) begin
        exp_t e;
        if (sys_clk2_en && !reset) begin
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got y=%0d phase=%0d, expected no output", y, y_phase);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    check({e.tag, "_y"}, int'(y), e.yv);
                    check({e.tag, "_phase"}, int'(y_phase), int'(e.ph));
                end
            end
        end
    end

    task automatic push_exp(input bit chk, input int yv, input bit ph, input string tag);
        exp_t e;
        e.chk = chk;
        e.yv  = yv;
        e.ph  = ph;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One input sample: even strobe with sam_clk_en, then n_odd odd-only strobes.
    task automatic issue(input int xv, input bit chk, input int ev, input int od,
                         input int n_odd, input string tag);
        @(negedge sys_clk);
        x_in        = 18'(xv);
        sam_clk_en  = 1'b1;
        sys_clk2_en = 1'b1;
        push_exp(chk, ev, 1'b0, {tag, "_even"});
        @(negedge sys_clk);
        sam_clk_en  = 1'b0;
        sys_clk2_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < n_odd; i++) begin
            sys_clk2_en = 1'b1;
            push_exp(chk, od, 1'b1, {tag, "_odd"});
            @(negedge sys_clk);
            sys_clk2_en = 1'b0;
            repeat (3) @(negedge sys_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ev_tab [8];
        int od_tab [8];
        int ovf_seq [8];
        ev_tab  = '{-160, 1572, -7848, 39204, 39204, -7848, 1572, -160};
        od_tab  = '{0, 0, 0, 65536, 0, 0, 0, 0};
        ovf_seq = '{-131071, 131071, -131071, 131071, 131071, -131071, 131071, -131071};

        repeat (5) @(negedge sys_clk);
        check("reset_y", int'(y), 0);
        check("reset_phase", int'(y_phase), 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) issue(0, 1'b1, 0, 0, 1, $sformatf("idle%0d", i));

        // Impulse response
        issue(65536, 1'b1, 0, 0, 1, "imp_pre");
        for (int i = 0; i < 8; i++) issue(0, 1'b1, ev_tab[i], od_tab[i], 1, $sformatf("imp%0d", i));
        issue(0, 1'b1, 0, 0, 1, "imp_tail");

        // DC gain: half scale, then full scale
        for (int i = 0; i < 12; i++) issue(65536, i >= 8, 65536, 65536, 1, $sformatf("dc_half%0d", i));
        for (int i = 0; i < 12; i++) issue(131071, i >= 8, 131071, 131071, 1, $sformatf("dc_full%0d", i));

        // Alternating full-scale pattern driving the even phase past full scale
        for (int i = 0; i < 8; i++) issue(ovf_seq[i], 1'b0, 0, 0, 1, "ovf_fill");
        issue(0, 1'b1, EXP_OVF, 131071, 1, "ovf");

        for (int i = 0; i < 8; i++) issue(0, 1'b0, 0, 0, 1, "flush");
        issue(0, 1'b1, 0, 0, 1, "flushed");

        // Impulse with a repeated odd strobe and a stray sam_clk_en
        issue(65536, 1'b1, 0, 0, 1, "imp2_pre");
        issue(0, 1'b1, -160, 0, 1, "imp2_1");
        issue(0, 1'b1, 1572, 0, 1, "imp2_2");
        issue(0, 1'b1, -7848, 0, 1, "imp2_3");
        issue(0, 1'b1, 39204, 65536, 2, "imp2_4dbl");

        @(negedge sys_clk);
        x_in       = '0;
        sam_clk_en = 1'b1;
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        repeat (7) @(negedge sys_clk);
        check("stray_sam_y_hold", int'(y), 65536);
        check("stray_sam_phase_hold", int'(y_phase), 1);

        issue(0, 1'b1, -7848, 0, 1, "imp2_5");
        issue(0, 1'b1, 1572, 0, 1, "imp2_6");
        issue(0, 1'b1, -160, 0, 1, "imp2_7");
        issue(0, 1'b1, 0, 0, 1, "imp2_8");

        // Mid-stream reset
        for (int i = 0; i < 5; i++) issue(65536, 1'b0, 0, 0, 1, "pre_rst");
        @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        check("midrst_y", int'(y), 0);
        check("midrst_phase", int'(y_phase), 0);
        reset = 1'b0;
        issue(65536, 1'b1, 0, 0, 1, "post_rst0");
        issue(65536, 1'b1, -160, 0, 1, "post_rst1");

        repeat (3) @(negedge sys_clk);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
